// File: rtl/legv8_ctrl_pkg.sv
// legv8_ctrl_pkg: opcodes, ALU encodings, FSM states and instruction classes
// shared by the single-cycle decoder and the multicycle sequencer.
package legv8_ctrl_pkg;
   localparam logic [5:0]  OP_B    = 6'b000101;
   localparam logic [5:0]  OP_BL   = 6'b100101;
   localparam logic [7:0]  OP_CBZ  = 8'b10110100;
   localparam logic [7:0]  OP_CBNZ = 8'b10110101;
   localparam logic [9:0]  OP_ADDI = 10'b1001000100;
   localparam logic [9:0]  OP_SUBI = 10'b1101000100;
   localparam logic [9:0]  OP_ANDI = 10'b1001001000;
   localparam logic [9:0]  OP_ORRI = 10'b1011001000;
   localparam logic [10:0] OP_ADD  = 11'b10001011000;
   localparam logic [10:0] OP_SUB  = 11'b11001011000;
   localparam logic [10:0] OP_AND  = 11'b10001010000;
   localparam logic [10:0] OP_ORR  = 11'b10101010000;
   localparam logic [10:0] OP_LDUR = 11'b11111000010;
   localparam logic [10:0] OP_STUR = 11'b11111000000;
   localparam logic [10:0] OP_BR   = 11'b11010110000;
   localparam logic [10:0] OP_HALT = 11'b11111111111;

   localparam logic [3:0] ALU_AND   = 4'd0;
   localparam logic [3:0] ALU_ORR   = 4'd1;
   localparam logic [3:0] ALU_ADD   = 4'd2;
   localparam logic [3:0] ALU_SUB   = 4'd6;
   localparam logic [3:0] ALU_PASSB = 4'd7;

   localparam logic [1:0] SRCB_REG  = 2'd0;
   localparam logic [1:0] SRCB_FOUR = 2'd1;
   localparam logic [1:0] SRCB_IMM  = 2'd2;

   localparam logic [1:0] PC_PLUS4  = 2'd0;
   localparam logic [1:0] PC_BRANCH = 2'd1;
   localparam logic [1:0] PC_REG    = 2'd2;

   typedef enum logic [2:0] {FETCH, DECODE, EXEC, MEM, WB, HALTED, FAULT} state_t;

   typedef enum logic [3:0] {
      CL_NOP, CL_R, CL_I, CL_LDUR, CL_STUR, CL_CBZ, CL_CBNZ, CL_B, CL_BL, CL_BR, CL_HALT
   } instr_class_t;

   // Shorter opcodes win, so a B/BL/CB prefix is never shadowed by a longer field.
   function automatic instr_class_t decode_class(input logic [10:0] op);
      if (op[10:5] == OP_B) decode_class = CL_B;
      else if (op[10:5] == OP_BL) decode_class = CL_BL;
      else if (op[10:3] == OP_CBZ) decode_class = CL_CBZ;
      else if (op[10:3] == OP_CBNZ) decode_class = CL_CBNZ;
      else if (op[10:1] inside {OP_ADDI, OP_SUBI, OP_ANDI, OP_ORRI}) decode_class = CL_I;
      else if (op inside {OP_ADD, OP_SUB, OP_AND, OP_ORR}) decode_class = CL_R;
      else if (op == OP_LDUR) decode_class = CL_LDUR;
      else if (op == OP_STUR) decode_class = CL_STUR;
      else if (op == OP_BR) decode_class = CL_BR;
      else if (op == OP_HALT) decode_class = CL_HALT;
      else decode_class = CL_NOP;
   endfunction
endpackage

// File: rtl/legv8_ctrl_decode.sv
// legv8_ctrl_decode: combinational opcode to class, ALU operation and ALU B-source lookup.
module legv8_ctrl_decode
   import legv8_ctrl_pkg::*;
(
   input  logic [10:0]  op,
   output instr_class_t cls,
   output logic [3:0]   alu_op,
   output logic [1:0]   alu_src_b
);
   always_comb begin
      cls = decode_class(op);
      alu_op = (cls == CL_CBZ || cls == CL_CBNZ) ? ALU_PASSB :
               cls == CL_R ? (op == OP_SUB ? ALU_SUB : op == OP_AND ? ALU_AND : op == OP_ORR ? ALU_ORR : ALU_ADD) :
               cls == CL_I ? (op[10:1] == OP_SUBI ? ALU_SUB : op[10:1] == OP_ANDI ? ALU_AND :
                              op[10:1] == OP_ORRI ? ALU_ORR : ALU_ADD) :
               ALU_ADD;
      alu_src_b = (cls == CL_I || cls == CL_LDUR || cls == CL_STUR) ? SRCB_IMM : SRCB_REG;
   end
endmodule

// File: rtl/legv8_multicycle_ctrl.sv
// legv8_multicycle_ctrl: FETCH/DECODE/EXEC/MEM/WB sequencer with memory-wait timeout.
// Optional CTRL_PERF_EN adds cycle and retired-instruction counters.
module legv8_multicycle_ctrl
   import legv8_ctrl_pkg::*;
#(
   parameter int INST_WIDTH   = 32,
   parameter int ALU_OP_WIDTH = 4,
   parameter int MEM_TIMEOUT  = 255,
   parameter int PERF_WIDTH   = 32
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [INST_WIDTH-1:0]   instr_in,
   input  logic                    zero_flag_in,
   input  logic                    mem_ready_in,
   output logic                    mem_read_out,
   output logic                    mem_write_out,
   output logic                    i_or_d_out,
   output logic                    ir_write_out,
   output logic                    pc_write_out,
   output logic [1:0]              pc_src_out,
   output logic                    reg_write_out,
   output logic                    mem_to_reg_out,
   output logic                    link_out,
   output logic [1:0]              alu_src_b_out,
   output logic [ALU_OP_WIDTH-1:0] alu_op_out,
   output logic [2:0]              state_out,
   output logic                    halted_out,
   output logic                    fault_out
`ifdef CTRL_PERF_EN
   ,
   output logic [PERF_WIDTH-1:0]   cycle_count_out,
   output logic [PERF_WIDTH-1:0]   instr_count_out
`endif
);
   localparam int CW = $clog2(MEM_TIMEOUT + 1);

   state_t       state, nxt;
   instr_class_t dec_cls, cls;
   logic [3:0]   dec_alu, op_q;
   logic [1:0]   dec_srcb, srcb_q;
   logic [CW-1:0] wait_cnt;
   logic         waiting, timeout, unused_low;

   assign unused_low = ^instr_in[INST_WIDTH-12:0];

   legv8_ctrl_decode u_dec (
      .op        (instr_in[INST_WIDTH-1 -: 11]),
      .cls       (dec_cls),
      .alu_op    (dec_alu),
      .alu_src_b (dec_srcb)
   );

   // A ready in the limit cycle still completes the access.
   assign waiting = (state == FETCH || state == MEM) && !mem_ready_in;
   assign timeout = waiting && wait_cnt == CW'(MEM_TIMEOUT - 1);

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= FETCH;
         wait_cnt <= '0;
         cls <= CL_NOP;
         op_q <= '0;
         srcb_q <= '0;
      end else begin
         state <= nxt;
         wait_cnt <= waiting ? wait_cnt + 1'b1 : '0;
         if (state == DECODE) begin
            cls <= dec_cls;
            op_q <= dec_alu;
            srcb_q <= dec_srcb;
         end
      end
   end

   always_comb begin
      nxt = state;
      mem_read_out = 1'b0;
      mem_write_out = 1'b0;
      i_or_d_out = 1'b0;
      ir_write_out = 1'b0;
      pc_write_out = 1'b0;
      pc_src_out = PC_PLUS4;
      reg_write_out = 1'b0;
      mem_to_reg_out = 1'b0;
      link_out = 1'b0;
      alu_src_b_out = SRCB_REG;
      alu_op_out = '0;
      state_out = '0;
      halted_out = 1'b0;
      fault_out = 1'b0;
      if (!rst) begin
         case (state)
            FETCH: begin
               nxt = mem_ready_in ? DECODE : timeout ? FAULT : FETCH;
               mem_read_out = 1'b1;
               ir_write_out = mem_ready_in;
               pc_write_out = mem_ready_in;
               alu_src_b_out = SRCB_FOUR;
               alu_op_out = ALU_OP_WIDTH'(ALU_ADD);
            end
            DECODE: begin
               nxt = dec_cls == CL_HALT ? HALTED :
                     dec_cls inside {CL_R, CL_I, CL_LDUR, CL_STUR, CL_CBZ, CL_CBNZ} ? EXEC : FETCH;
               pc_write_out = dec_cls inside {CL_B, CL_BL, CL_BR};
               pc_src_out = dec_cls == CL_BR ? PC_REG : dec_cls inside {CL_B, CL_BL} ? PC_BRANCH : PC_PLUS4;
               reg_write_out = dec_cls == CL_BL;
               link_out = dec_cls == CL_BL;
            end
            EXEC: begin
               nxt = cls inside {CL_LDUR, CL_STUR} ? MEM : cls inside {CL_R, CL_I} ? WB : FETCH;
               alu_op_out = ALU_OP_WIDTH'(op_q);
               alu_src_b_out = srcb_q;
               pc_write_out = (cls == CL_CBZ && zero_flag_in) || (cls == CL_CBNZ && !zero_flag_in);
               pc_src_out = cls inside {CL_CBZ, CL_CBNZ} ? PC_BRANCH : PC_PLUS4;
            end
            MEM: begin
               nxt = mem_ready_in ? FETCH : timeout ? FAULT : MEM;
               i_or_d_out = 1'b1;
               mem_read_out = cls == CL_LDUR;
               mem_write_out = cls == CL_STUR;
               reg_write_out = mem_ready_in && cls == CL_LDUR;
               mem_to_reg_out = mem_ready_in && cls == CL_LDUR;
            end
            WB: begin
               nxt = FETCH;
               reg_write_out = 1'b1;
            end
            default: ;
         endcase
         state_out = state;
         halted_out = state == HALTED;
         fault_out = state == FAULT;
      end
   end

`ifdef CTRL_PERF_EN
   logic [PERF_WIDTH-1:0] cyc_q, ins_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         cyc_q <= '0;
         ins_q <= '0;
      end else begin
         if (state != HALTED && state != FAULT) cyc_q <= cyc_q + 1'b1;
         if (state != FETCH && nxt == FETCH) ins_q <= ins_q + 1'b1;
      end
   end

   assign cycle_count_out = rst ? '0 : cyc_q;
   assign instr_count_out = rst ? '0 : ins_q;
`else
   localparam int unused_perf_width = PERF_WIDTH;
`endif
endmodule

// File: tb/tb_legv8_multicycle_ctrl.sv
// tb_legv8_multicycle_ctrl: random instruction/wait-state stimulus scored against
// a per-instruction summary model (cycles, strobe pulse counts, end state).
module tb_legv8_multicycle_ctrl;
   import legv8_ctrl_pkg::*;

   localparam int T = 4;
   localparam int KN = 0, KR = 1, KL = 2, KS = 3, KCZ = 4, KCN = 5, KB = 6, KBL = 7, KBR = 8, KH = 9;

   logic        clk = 1'b0, rst = 1'b1;
   logic [31:0] instr_in = '0;
   logic        zero_flag_in = 1'b0, mem_ready_in = 1'b0;
   logic        mem_read_out, mem_write_out, i_or_d_out, ir_write_out, pc_write_out;
   logic [1:0]  pc_src_out, alu_src_b_out;
   logic        reg_write_out, mem_to_reg_out, link_out, halted_out, fault_out;
   logic [3:0]  alu_op_out;
   logic [2:0]  state_out;
`ifdef CTRL_PERF_EN
   logic [31:0] cycle_count_out, instr_count_out;
`endif
   logic [20:0] all_outs;

   assign all_outs = {mem_read_out, mem_write_out, i_or_d_out, ir_write_out, pc_write_out, pc_src_out,
                      reg_write_out, mem_to_reg_out, link_out, alu_src_b_out, alu_op_out, state_out,
                      halted_out, fault_out};

   legv8_multicycle_ctrl #(.MEM_TIMEOUT(T)) dut (
      .clk(clk), .rst(rst), .instr_in(instr_in), .zero_flag_in(zero_flag_in), .mem_ready_in(mem_ready_in),
      .mem_read_out(mem_read_out), .mem_write_out(mem_write_out), .i_or_d_out(i_or_d_out),
      .ir_write_out(ir_write_out), .pc_write_out(pc_write_out), .pc_src_out(pc_src_out),
      .reg_write_out(reg_write_out), .mem_to_reg_out(mem_to_reg_out), .link_out(link_out),
      .alu_src_b_out(alu_src_b_out), .alu_op_out(alu_op_out), .state_out(state_out),
      .halted_out(halted_out), .fault_out(fault_out)
`ifdef CTRL_PERF_EN
      , .cycle_count_out(cycle_count_out), .instr_count_out(instr_count_out)
`endif
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] base;
      int          fixed;
      int          kind;
      logic [3:0]  alu;
      logic [1:0]  srcb;
   } op_t;

   op_t tbl [17];
   int  checks = 0, errors = 0;
   int  p_cyc = 0, p_ins = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic do_reset();
      rst = 1'b1;
      mem_ready_in = 1'b0;
      @(posedge clk);
      #2;
      check("rst_outs", 32'(all_outs), 32'd0);
      rst = 1'b0;
      p_cyc = 0;
      p_ins = 0;
      #1;
      check("rst_fetch", 32'(state_out), 32'd0);
      check("rst_fault", 32'(fault_out), 32'd0);
   endtask

   // Plays memory (fw/mw wait cycles per access) and summarises one instruction.
   task automatic run(input logic [31:0] ins, input int kind, input logic [3:0] alu, input logic [1:0] srcb,
                      input int fw, input int mw, input logic z, output int e_end, output logic [23:0] trace);
      int cyc = 0, irw = 0, pcw = 0, rgw = 0, lnk = 0, m2r = 0, mrd = 0, mwr = 0, iod = 0, acc = 0, waited = 0;
      int e_cyc = 0, e_irw = 0, e_pcw = 0, e_rgw = 0, e_lnk = 0, e_m2r = 0, e_mrd = 0, e_mwr = 0, e_iod = 0;
      int dcyc;
      logic [1:0] maxsrc = 0, e_src = 0;
      logic [3:0] ex_alu = '1;
      logic [1:0] ex_srcb = '1;
      logic [2:0] s, s2;
      bit done = 0;
      trace = '0;
      instr_in = ins;
      zero_flag_in = z;
      s = state_out;
      while (!done && cyc < 60) begin
         mem_ready_in = (mem_read_out || mem_write_out) && waited == (acc == 0 ? fw : mw);
         #1;
         trace = {trace[20:0], state_out};
         irw += 32'(ir_write_out);
         pcw += 32'(pc_write_out);
         rgw += 32'(reg_write_out);
         lnk += 32'(link_out);
         m2r += 32'(mem_to_reg_out);
         mrd += 32'(mem_read_out);
         mwr += 32'(mem_write_out);
         iod += 32'(i_or_d_out);
         if (pc_write_out && pc_src_out > maxsrc) maxsrc = pc_src_out;
         if (state_out == 3'd2) begin
            ex_alu = alu_op_out;
            ex_srcb = alu_src_b_out;
         end
         if (mem_read_out || mem_write_out) begin
            if (mem_ready_in) begin
               acc++;
               waited = 0;
            end else waited++;
         end
         @(posedge clk);
         #2;
         cyc++;
         s2 = state_out;
         done = (s2 == 3'd0 && s != 3'd0) || s2 == 3'd5 || s2 == 3'd6;
         s = s2;
      end
      mem_ready_in = 1'b0;
      check("done", 32'(done), 32'd1);
      e_end = 0;
      if (fw >= T) begin
         e_cyc = T;
         e_mrd = T;
         e_end = 6;
      end else begin
         e_irw = 1;
         e_pcw = 1;
         e_mrd = fw + 1;
         e_cyc = fw + 2;
         case (kind)
            KR: begin e_cyc += 2; e_rgw = 1; end
            KL, KS: begin
               dcyc = mw < T ? mw + 1 : T;
               e_cyc += 1 + dcyc;
               e_iod = dcyc;
               if (kind == KL) e_mrd += dcyc; else e_mwr = dcyc;
               if (mw < T) begin
                  e_rgw = kind == KL ? 1 : 0;
                  e_m2r = e_rgw;
               end else e_end = 6;
            end
            KCZ, KCN: begin
               e_cyc += 1;
               if ((kind == KCZ) == z) begin e_pcw = 2; e_src = 1; end
            end
            KB: begin e_pcw = 2; e_src = 1; end
            KBL: begin e_pcw = 2; e_src = 1; e_rgw = 1; e_lnk = 1; end
            KBR: begin e_pcw = 2; e_src = 2; end
            KH: e_end = 5;
            default: ;
         endcase
      end
      check("cycles", cyc, e_cyc);
      check("end_state", 32'(s), e_end);
      check("ir_write", irw, e_irw);
      check("pc_write", pcw, e_pcw);
      check("pc_src", 32'(maxsrc), 32'(e_src));
      check("reg_write", rgw, e_rgw);
      check("link", lnk, e_lnk);
      check("mem_to_reg", m2r, e_m2r);
      check("mem_read", mrd, e_mrd);
      check("mem_write", mwr, e_mwr);
      check("i_or_d", iod, e_iod);
      if (fw < T && kind inside {KR, KL, KS, KCZ, KCN}) begin
         check("exec_alu", 32'(ex_alu), 32'(alu));
         check("exec_srcb", 32'(ex_srcb), 32'(srcb));
      end
      p_cyc += e_cyc;
      if (e_end == 0) p_ins++;
`ifdef CTRL_PERF_EN
      check("cycle_count", cycle_count_out, p_cyc);
      check("instr_count", instr_count_out, p_ins);
`endif
   endtask

   task automatic run_k(input int k, input int fw, input int mw, input logic z, output int e_end);
      logic [31:0] ins;
      logic [23:0] tr;
      ins = tbl[k].base | ($urandom & ((32'd1 << (32 - tbl[k].fixed)) - 32'd1));
      run(ins, tbl[k].kind, tbl[k].alu, tbl[k].srcb, fw, mw, z, e_end, tr);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog");
      $fatal(1);
   end

   initial begin
      int e_end;
      int fw, mw;
      logic [23:0] tr;
      tbl[0]  = '{{11'b10001011000, 21'b0}, 11, KR,  ALU_ADD,   2'd0};
      tbl[1]  = '{{11'b11001011000, 21'b0}, 11, KR,  ALU_SUB,   2'd0};
      tbl[2]  = '{{11'b10001010000, 21'b0}, 11, KR,  ALU_AND,   2'd0};
      tbl[3]  = '{{11'b10101010000, 21'b0}, 11, KR,  ALU_ORR,   2'd0};
      tbl[4]  = '{{10'b1001000100, 22'b0},  10, KR,  ALU_ADD,   2'd2};
      tbl[5]  = '{{10'b1101000100, 22'b0},  10, KR,  ALU_SUB,   2'd2};
      tbl[6]  = '{{10'b1001001000, 22'b0},  10, KR,  ALU_AND,   2'd2};
      tbl[7]  = '{{10'b1011001000, 22'b0},  10, KR,  ALU_ORR,   2'd2};
      tbl[8]  = '{{11'b11111000010, 21'b0}, 11, KL,  ALU_ADD,   2'd2};
      tbl[9]  = '{{11'b11111000000, 21'b0}, 11, KS,  ALU_ADD,   2'd2};
      tbl[10] = '{{8'b10110100, 24'b0},     8,  KCZ, ALU_PASSB, 2'd0};
      tbl[11] = '{{8'b10110101, 24'b0},     8,  KCN, ALU_PASSB, 2'd0};
      tbl[12] = '{{6'b000101, 26'b0},       6,  KB,  4'd0,      2'd0};
      tbl[13] = '{{6'b100101, 26'b0},       6,  KBL, 4'd0,      2'd0};
      tbl[14] = '{{11'b11010110000, 21'b0}, 11, KBR, 4'd0,      2'd0};
      tbl[15] = '{{11'b00000000000, 21'b0}, 11, KN,  4'd0,      2'd0};
      tbl[16] = '{{11'b11111111111, 21'b0}, 11, KH,  4'd0,      2'd0};

      do_reset();

      run(32'h91001421, KR, ALU_ADD, 2'd2, 0, 0, 1'b0, e_end, tr);
      check("addi_trace", 32'(tr), 32'({3'd0, 3'd1, 3'd2, 3'd4}));
      run_k(8, 0, 3, 1'b0, e_end);
      run_k(10, 1, 0, 1'b1, e_end);
      run_k(11, 0, 0, 1'b1, e_end);
      run_k(8, 0, 4, 1'b0, e_end);
      do_reset();

      run_k(0, T, 0, 1'b0, e_end);
      check("fault_sticky", 32'(fault_out), 32'd1);
      @(posedge clk);
      #2;
      check("fault_hold", 32'({fault_out, mem_read_out}), 32'b10);
      do_reset();

      run(32'hFFE00000, KH, 4'd0, 2'd0, 1, 0, 1'b0, e_end, tr);
      for (int i = 0; i < 5; i++) begin
         mem_ready_in = 1'b1;
         #1;
         check("halted", 32'({halted_out, ir_write_out, mem_read_out}), 32'b100);
         @(posedge clk);
         #2;
      end
`ifdef CTRL_PERF_EN
      check("halt_cycles", cycle_count_out, p_cyc);
`endif
      do_reset();

      instr_in = {11'b11111000000, 21'h1234};
      mem_ready_in = 1'b1;
      @(posedge clk);
      #2;
      mem_ready_in = 1'b0;
      check("stur_dec", 32'(state_out), 32'd1);
      @(posedge clk);
      #2;
      @(posedge clk);
      #2;
      check("stur_mem", 32'({state_out, mem_write_out, reg_write_out, pc_write_out}), 32'({3'd3, 3'b100}));
      rst = 1'b1;
      #1;
      check("stur_rst", 32'(all_outs), 32'd0);
      @(posedge clk);
      #2;
      rst = 1'b0;
      p_cyc = 0;
      p_ins = 0;
      #1;
      check("stur_fetch", 32'({state_out, mem_write_out, mem_read_out}), 32'b00001);

      for (int n = 0; n < 200; n++) begin
         fw = $urandom_range(0, 15) == 0 ? T : $urandom_range(0, 3);
         mw = $urandom_range(0, 15) == 0 ? T : $urandom_range(0, 3);
         run_k($urandom_range(0, 16), fw, mw, 1'($urandom_range(0, 1)), e_end);
         if (e_end != 0) do_reset();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
